// File: rtl/mem_bus_arbiter.sv
// Two-to-one arbiter sharing one memory request port between ibus (fetch) and dbus.
// Optional macro ARB_ROUND_ROBIN_EN switches contention resolution from fixed dbus priority to round robin.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2:0]          d_size,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [2:0]          m_size,
  output logic [DATA_W/8-1:0] m_strobe,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_DATA = 3'd2,
    D_ADDR = 3'd3,
    D_DATA = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   last_d_q, last_d_d;  // last owner was dbus
  logic   own_i, own_d, req_phase, data_phase, owner_valid, accept, done;

  // Owner: picked combinationally in IDLE, otherwise held by the state register
  always_comb begin
    own_i = 1'b0;
    own_d = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (d_valid && i_valid) begin
          own_d = !last_d_q;
          own_i = last_d_q;
        end else begin
          own_d = d_valid;
          own_i = i_valid;
        end
`else
        own_d = d_valid;
        own_i = !d_valid && i_valid;
`endif
      end
      I_ADDR, I_DATA: own_i = 1'b1;
      D_ADDR, D_DATA: own_d = 1'b1;
      default: ;
    endcase
  end

  assign req_phase   = (state_q == IDLE) || (state_q == I_ADDR) || (state_q == D_ADDR);
  assign data_phase  = (state_q == I_DATA) || (state_q == D_DATA);
  assign owner_valid = (own_i && i_valid) || (own_d && d_valid);
  assign m_valid     = resetn && req_phase && owner_valid;
  assign accept      = m_valid && m_addr_ok;
  // data_ok before the address is accepted is ignored
  assign done        = resetn && m_data_ok && (data_phase || accept);

  assign i_addr_ok = own_i && accept;
  assign d_addr_ok = own_d && accept;
  assign i_data_ok = own_i && done;
  assign d_data_ok = own_d && done;
  assign i_rdata   = resetn ? m_rdata : '0;
  assign d_rdata   = resetn ? m_rdata : '0;

  // Request payload mux; ibus is always a word read
  always_comb begin
    m_addr   = '0;
    m_size   = 3'd0;
    m_strobe = '0;
    m_wdata  = '0;
    if (resetn && own_d) begin
      m_addr   = d_addr;
      m_size   = d_size;
      m_strobe = d_strobe;
      m_wdata  = d_wdata;
    end else if (resetn && own_i) begin
      m_addr   = i_addr;
      m_size   = 3'd2;
      m_strobe = STRB_W'(0);
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    if (own_i || own_d) begin
      if (req_phase) begin
        if (!owner_valid || (m_addr_ok && m_data_ok)) begin
          state_d  = IDLE;
          last_d_d = own_d;
        end else if (m_addr_ok) begin
          state_d = own_d ? D_DATA : I_DATA;
        end else begin
          state_d = own_d ? D_ADDR : I_ADDR;
        end
      end else if (m_data_ok) begin
        state_d  = IDLE;
        last_d_d = own_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; contention expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, d_valid, m_addr_ok, m_data_ok;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [2:0]  d_size;
  logic [3:0]  d_strobe;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_valid;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [2:0]  m_size;
  logic [3:0]  m_strobe;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_valid = 0; d_valid = 0; m_addr_ok = 0; m_data_ok = 0;
    i_addr = 0; d_addr = 0; d_size = 3'd2; d_strobe = 0; d_wdata = 0; m_rdata = 0;
  endtask

  task automatic test_reset;
    resetn = 0; i_valid = 1; d_valid = 1; i_addr = 32'h1234_5678; d_addr = 32'h8000_0010;
    d_strobe = 4'hF; d_wdata = 32'hCAFE_F00D; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hA5A5_A5A5;
    #1;
    n_checks++;
    if ({m_valid, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok} !== 5'b0) begin
      n_fail++; $display("FAIL reset_oks got %b want 00000", {m_valid, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok});
    end
    n_checks++;
    if ({m_addr, m_wdata, m_size, m_strobe} !== '0) begin
      n_fail++; $display("FAIL reset_payload got addr %h wdata %h size %0d strb %h want 0", m_addr, m_wdata, m_size, m_strobe);
    end
    n_checks++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata got %h %h want 0", i_rdata, d_rdata);
    end
    tick();
    idle_inputs();
    resetn = 1;
    tick();
  endtask

  task automatic test_ibus_read;
    // cycle 0: request accepted immediately
    i_valid = 1; i_addr = 32'hBFC0_0000; m_addr_ok = 1;
    #1;
    n_checks++;
    if ({m_valid, m_addr, m_size, m_strobe} !== {1'b1, 32'hBFC0_0000, 3'd2, 4'h0}) begin
      n_fail++; $display("FAIL ibus_req got v%b %h sz%0d st%h want v1 bfc00000 sz2 st0", m_valid, m_addr, m_size, m_strobe);
    end
    n_checks++;
    if ({i_addr_ok, d_addr_ok} !== 2'b10) begin
      n_fail++; $display("FAIL ibus_addr_ok got %b want 10", {i_addr_ok, d_addr_ok});
    end
    tick();
    i_valid = 0; m_addr_ok = 0;
    #1;
    n_checks++;
    if ({m_valid, i_data_ok, d_data_ok} !== 3'b000) begin
      n_fail++; $display("FAIL ibus_wait got %b want 000", {m_valid, i_data_ok, d_data_ok});
    end
    tick();
    m_data_ok = 1; m_rdata = 32'h3C1D_0000;
    #1;
    n_checks++;
    if ({i_data_ok, d_data_ok, d_addr_ok, i_rdata} !== {3'b100, 32'h3C1D_0000}) begin
      n_fail++; $display("FAIL ibus_data got %b %h want 100 3c1d0000", {i_data_ok, d_data_ok, d_addr_ok}, i_rdata);
    end
    tick();
    // cycle 3: back in IDLE, a dbus request forwarded same cycle and done single-cycle
    m_data_ok = 0; d_valid = 1; d_addr = 32'h8000_0040; d_size = 3'd2; m_addr_ok = 1; m_data_ok = 1;
    #1;
    n_checks++;
    if ({m_valid, m_addr, d_addr_ok, d_data_ok, i_data_ok} !== {1'b1, 32'h8000_0040, 3'b110}) begin
      n_fail++; $display("FAIL single_cycle got v%b %h %b want v1 80000040 110", m_valid, m_addr, {d_addr_ok, d_data_ok, i_data_ok});
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_cycle_idle got m_valid %b want 0", m_valid);
    end
    tick();
  endtask

  task automatic test_contention;
    logic        last_d;
    logic        first_d;
    logic [31:0] first_addr, second_addr;
    logic [1:0]  first_mask, second_mask;
    last_d = 1'b1;
    for (int r = 0; r < 2; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
      first_d = !last_d;
`else
      first_d = 1'b1;
`endif
      first_addr  = first_d ? 32'h8000_1000 : 32'hBFC0_0004;
      second_addr = first_d ? 32'hBFC0_0004 : 32'h8000_1000;
      first_mask  = first_d ? 2'b01 : 2'b10;
      second_mask = ~first_mask;
      i_valid = 1; i_addr = 32'hBFC0_0004;
      d_valid = 1; d_addr = 32'h8000_1000; d_size = 3'd2; d_strobe = 4'hF; d_wdata = 32'hDEAD_BEEF;
      m_addr_ok = 1; m_data_ok = 0;
      #1;
      n_checks++;
      if ({m_addr, i_addr_ok, d_addr_ok} !== {first_addr, first_mask}) begin
        n_fail++; $display("FAIL contend_first r%0d got %h %b want %h %b", r, m_addr, {i_addr_ok, d_addr_ok}, first_addr, first_mask);
      end
      n_checks++;
      if ({m_strobe, m_wdata} !== (first_d ? {4'hF, 32'hDEAD_BEEF} : 36'h0)) begin
        n_fail++; $display("FAIL contend_payload r%0d got %h %h", r, m_strobe, m_wdata);
      end
      tick();
      if (first_d) d_valid = 0; else i_valid = 0;
      m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h0BAD_F00D + 32'(r);
      #1;
      n_checks++;
      if ({m_valid, i_data_ok, d_data_ok} !== {1'b0, first_mask}) begin
        n_fail++; $display("FAIL contend_first_done r%0d got %b want 0%b", r, {m_valid, i_data_ok, d_data_ok}, first_mask);
      end
      tick();
      m_addr_ok = 1; m_data_ok = 1;
      #1;
      n_checks++;
      if ({m_valid, m_addr, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== {1'b1, second_addr, second_mask, second_mask}) begin
        n_fail++; $display("FAIL contend_second r%0d got v%b %h %b want v1 %h %b%b", r, m_valid, m_addr,
                           {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, second_addr, second_mask, second_mask);
      end
      tick();
      last_d = !first_d;
      idle_inputs();
      tick();
    end
  endtask

  task automatic test_addr_stall;
    i_valid = 1; i_addr = 32'h0040_0000;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        d_valid = 1; d_addr = 32'h8000_2000; d_size = 3'd0; d_strobe = 4'h1; d_wdata = 32'h0000_0055;
      end
      m_data_ok = (c == 2);
      #1;
      n_checks++;
      if ({m_valid, m_addr, d_addr_ok, i_data_ok} !== {1'b1, 32'h0040_0000, 2'b00}) begin
        n_fail++; $display("FAIL stall_c%0d got v%b %h %b want v1 00400000 00", c, m_valid, m_addr, {d_addr_ok, i_data_ok});
      end
      tick();
    end
    m_data_ok = 0; m_addr_ok = 1;
    #1;
    n_checks++;
    if ({i_addr_ok, d_addr_ok, m_addr} !== {2'b10, 32'h0040_0000}) begin
      n_fail++; $display("FAIL stall_accept got %b %h want 10 00400000", {i_addr_ok, d_addr_ok}, m_addr);
    end
    tick();
    i_valid = 0;
    #1;
    n_checks++;
    if ({m_valid, d_addr_ok} !== 2'b00) begin
      n_fail++; $display("FAIL stall_locked got %b want 00", {m_valid, d_addr_ok});
    end
    tick();
    m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1111_2222;
    #1;
    n_checks++;
    if ({i_data_ok, d_addr_ok, d_data_ok} !== 3'b100) begin
      n_fail++; $display("FAIL stall_idata got %b want 100", {i_data_ok, d_addr_ok, d_data_ok});
    end
    tick();
    m_addr_ok = 1; m_data_ok = 1;
    #1;
    n_checks++;
    if ({m_valid, m_addr, m_size, m_strobe, d_addr_ok, d_data_ok} !== {1'b1, 32'h8000_2000, 3'd0, 4'h1, 2'b11}) begin
      n_fail++; $display("FAIL stall_dgrant got v%b %h sz%0d st%h %b want v1 80002000 sz0 st1 11",
                         m_valid, m_addr, m_size, m_strobe, {d_addr_ok, d_data_ok});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_protocol_violation;
    i_valid = 1; i_addr = 32'h0040_0100;
    tick();
    i_valid = 0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL viol_drop got m_valid %b want 0", m_valid);
    end
    tick();
    d_valid = 1; d_addr = 32'h8000_3000; m_addr_ok = 1; m_data_ok = 1;
    #1;
    n_checks++;
    if ({m_valid, m_addr, d_addr_ok, d_data_ok} !== {1'b1, 32'h8000_3000, 2'b11}) begin
      n_fail++; $display("FAIL viol_recover got v%b %h %b want v1 80003000 11", m_valid, m_addr, {d_addr_ok, d_data_ok});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid;
    i_valid = 1; i_addr = 32'h0040_0200; m_addr_ok = 1;
    tick();
    i_valid = 0; m_addr_ok = 0;
    d_valid = 1; d_addr = 32'h8000_4000; d_size = 3'd2; d_strobe = 4'h0;
    resetn = 0; m_data_ok = 1; m_rdata = 32'h7777_8888;
    #1;
    n_checks++;
    if ({m_valid, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_addr, i_rdata} !== '0) begin
      n_fail++; $display("FAIL rst_mid got %b %h %h want 0", {m_valid, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, m_addr, i_rdata);
    end
    tick();
    resetn = 1; m_data_ok = 0; m_addr_ok = 1;
    #1;
    n_checks++;
    if ({m_valid, m_addr, d_addr_ok, i_data_ok} !== {1'b1, 32'h8000_4000, 2'b10}) begin
      n_fail++; $display("FAIL rst_release got v%b %h %b want v1 80004000 10", m_valid, m_addr, {d_addr_ok, i_data_ok});
    end
    tick();
    d_valid = 0; m_addr_ok = 0; m_data_ok = 1;
    #1;
    n_checks++;
    if ({d_data_ok, i_data_ok} !== 2'b10) begin
      n_fail++; $display("FAIL rst_ddone got %b want 10", {d_data_ok, i_data_ok});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    tick();
    test_reset();
    test_ibus_read();
    test_contention();
    test_addr_stall();
    test_protocol_violation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory request port between the core's instruction bus (fetch) and data bus (memory stage).
- Sits between the core's ibus/dbus and the cache/AXI bridge.
- Allows one transaction in flight at a time.
- Locks the grant from selection until the memory returns data_ok, so a requester sees a clean, uninterleaved handshake.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- i_valid  in  1  ibus request valid; held high until i_addr_ok
- i_addr  in  ADDR_W  ibus address
- i_addr_ok  out  1  ibus request accepted
- i_data_ok  out  1  ibus read data valid
- i_rdata  out  DATA_W  ibus read data
- d_valid  in  1  dbus request valid; held high until d_addr_ok
- d_addr  in  ADDR_W  dbus address
- d_size  in  3  dbus access size code
- d_strobe  in  DATA_W/8  byte write strobe; all-zero means read
- d_wdata  in  DATA_W  dbus write data
- d_addr_ok  out  1  dbus request accepted
- d_data_ok  out  1  dbus transaction complete
- d_rdata  out  DATA_W  dbus read data
- m_valid  out  1  memory request valid
- m_addr  out  ADDR_W  memory address
- m_size  out  3  size; ibus uses word code 3'd2
- m_strobe  out  DATA_W/8  strobe; ibus always 0
- m_wdata  out  DATA_W  write data; ibus 0
- m_addr_ok  in  1  memory accepted request
- m_data_ok  in  1  memory response valid
- m_rdata  in  DATA_W  memory read data

Behaviour:
- One clock (clk). Reset is synchronous and active-low (resetn). All state updates on posedge clk.
- States: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
- Reset: state <= IDLE; last_owner <= I. While resetn=0, every output is forced to 0.
- Owner:
  - IDLE: the owner is selected combinationally. Fixed priority: if d_valid, the owner is D; else if i_valid, the owner is I; else none.
  - X_ADDR and X_DATA: the owner is X, held by the state register.
- Request path: m_valid = owner's valid when the state is IDLE (with an owner) or X_ADDR. m_valid = 0 in X_DATA. m_addr, m_size, m_strobe and m_wdata are muxed from the owner; they are 0 when there is no owner.
- Response path:
  - Owner: X_addr_ok = m_valid & m_addr_ok; X_data_ok = m_data_ok while X owns the bus (IDLE-selected, X_ADDR or X_DATA).
  - Non-owner: addr_ok = 0, data_ok = 0.
  - i_rdata and d_rdata are both driven with m_rdata unconditionally.
- Transitions from IDLE (with an owner) or X_ADDR:
  - m_addr_ok & m_data_ok -> IDLE (single-cycle transaction).
  - m_addr_ok only -> X_DATA.
  - Neither -> X_ADDR. The grant stays locked; a newly arriving higher-priority request waits.
- X_DATA: m_data_ok -> IDLE; otherwise stay.
- last_owner <= X on every return to IDLE.
- Latency: zero added cycles. The request is forwarded in the same cycle it is presented; a back-to-back request from the other bus is forwarded in the cycle after data_ok.
- Protocol violation (owner drops valid in X_ADDR): return to IDLE next cycle, m_valid = 0.
- m_data_ok in IDLE or X_ADDR without a prior accept: ignored, no state change.
- Reset mid-transaction: state -> IDLE immediately; the memory side is reset in the same cycle.
- Simultaneous i_valid and d_valid in IDLE: resolved per the priority rule; the loser keeps valid high and is served after completion.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: IDLE selection with both valid grants the bus opposite to last_owner (last_owner=D -> I wins; last_owner=I -> D wins). With a single requester, that requester wins.
- Undefined: fixed dbus priority. last_owner is still maintained but unused.

Test Plan:
- Single ibus read to 0xBFC00000, memory returns addr_ok at cycle 0 and data_ok with 0x3C1D0000 at cycle 2 -> i_addr_ok at cycle 0, i_data_ok with that data at cycle 2, d_* oks stay 0, state IDLE at cycle 3.
- i_valid and d_valid both high in IDLE, macro off -> dbus (addr 0x80001000, strobe 4'hF, wdata 0xDEADBEEF) forwarded first; ibus forwarded the cycle after d_data_ok.
- Same stimulus with ARB_ROUND_ROBIN_EN and last_owner=D -> ibus served first; repeated contention alternates I, D, I, D.
- m_addr_ok held low 3 cycles while d_valid rises during I_ADDR -> m_addr stays the ibus address all 3 cycles; the dbus is granted only after i_data_ok.
- m_addr_ok and m_data_ok both high in the same cycle in IDLE -> data_ok to the owner that cycle, state remains IDLE, and the next request is forwarded the following cycle.
- resetn low for 1 cycle during I_DATA -> all outputs 0 that cycle; state IDLE after release; a pending d_valid is forwarded in the first cycle after release.
